// File: rtl/run_det_pkg.sv
`default_nettype none
// ============================================================================
// Module   : run_det_pkg
// Purpose  : Shared types and constants for the run_detector block.
// Revision : 1.0 - initial release
// ============================================================================
package run_det_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ZERO = 2'd1,
    ONES = 2'd2,
    HOLD = 2'd3
  } run_det_state_t;

  localparam logic MODE_EXACT   = 1'b0;
  localparam logic MODE_ATLEAST = 1'b1;

endpackage
`default_nettype wire

// File: rtl/run_detector_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Saturating up-counter with synchronous clear and increment enable.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  // Clear beats increment; the counter sticks once it reaches all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/run_detector.sv
`default_nettype none
// ============================================================================
// Module   : run_detector
// Purpose  : Flags a zero-bracketed run of RUN_LEN ones (exact or at-least),
//            holds the flag until acknowledged and counts detections.
// Revision : 1.0 - initial release
// ============================================================================
module run_detector
  import run_det_pkg::*;
#(
  parameter  int RUN_LEN = 5,
  parameter  int DET_W   = 8,
  localparam int CW      = $clog2(RUN_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             j,
  input  logic             en,
  input  logic             mode,
  input  logic             clr,
  output logic             w,
  output logic [CW-1:0]    run_cnt,
  output logic [DET_W-1:0] det_cnt
);

  localparam logic [CW-1:0] c_run_max = CW'(RUN_LEN);

  run_det_state_t r_state;
  run_det_state_t w_state_nxt;
  logic [CW-1:0]  r_run_cnt;
  logic [CW-1:0]  w_run_nxt;
  logic           w_det_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_run_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_run_cnt <= w_run_nxt;
    end
  end

  always_comb begin
    w_state_nxt = IDLE;
    w_run_nxt   = '0;
    w_det_inc   = 1'b0;
    case (r_state)
      IDLE: begin
        w_state_nxt = j ? IDLE : ZERO;
      end
      ZERO: begin
        if (j) begin
          w_state_nxt = ONES;
          w_run_nxt   = CW'(1);
        end else begin
          w_state_nxt = ZERO;
        end
      end
      ONES: begin
        if (j) begin
          if (r_run_cnt < c_run_max) begin
            w_state_nxt = ONES;
            w_run_nxt   = r_run_cnt + CW'(1);
          end else if (mode == MODE_ATLEAST) begin
            w_state_nxt = ONES;
            w_run_nxt   = c_run_max;
          end else begin
            // Run overshot in exact mode: demand a fresh leading zero.
            w_state_nxt = IDLE;
          end
        end else if (r_run_cnt == c_run_max) begin
          w_state_nxt = HOLD;
          w_run_nxt   = c_run_max;
          w_det_inc   = 1'b1;
        end else begin
          // The terminating zero of a short run is the next leading zero.
          w_state_nxt = ZERO;
        end
      end
      HOLD: begin
        if (!en) begin
          w_state_nxt = HOLD;
          w_run_nxt   = c_run_max;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    w = (r_state == HOLD);
  end

  assign run_cnt = r_run_cnt;

  sat_counter #(
    .W (DET_W)
  ) u_det_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (w_det_inc),
    .cnt (det_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_run_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_run_detector
// Purpose  : Directed vector table, detection-counter saturation and random
//            stimulus against a run-length reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_run_detector;

  localparam int RUN_LEN = 5;
  localparam int DET_W   = 2;
  localparam int DET_MAX = (1 << DET_W) - 1;

  logic             clk;
  logic             rst;
  logic             j;
  logic             en;
  logic             mode;
  logic             clr;
  logic             w;
  logic [2:0]       run_cnt;
  logic [DET_W-1:0] det_cnt;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic       j, en, mode, clr, rst;
    logic       w;
    logic [2:0] run;
    logic [1:0] det;
  } vec_t;

  vec_t tbl[$];

  run_detector #(
    .RUN_LEN (RUN_LEN),
    .DET_W   (DET_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .j       (j),
    .en      (en),
    .mode    (mode),
    .clr     (clr),
    .w       (w),
    .run_cnt (run_cnt),
    .det_cnt (det_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: length of the current armed run, unbounded.
  int m_ones;
  bit m_lead;
  bit m_hold;
  int m_det;

  task automatic model_step(input logic mj, men, mmode, mclr, mrst);
    bit hit;
    hit = 1'b0;
    if (mrst) begin
      m_ones = 0; m_lead = 0; m_hold = 0; m_det = 0;
      return;
    end
    if (m_hold) begin
      if (men) begin
        m_hold = 0; m_lead = 0; m_ones = 0;
      end
    end else if (!mj) begin
      if (m_lead && m_ones >= RUN_LEN) begin
        m_hold = 1; hit = 1'b1;
      end else begin
        m_lead = 1; m_ones = 0;
      end
    end else if (m_lead) begin
      if (m_ones >= RUN_LEN && mmode == 1'b0) begin
        m_lead = 0; m_ones = 0;
      end else begin
        m_ones++;
      end
    end
    if (mclr) m_det = 0;
    else if (hit && m_det < DET_MAX) m_det++;
  endtask

  function automatic int model_run();
    if (m_hold) return RUN_LEN;
    if (!m_lead) return 0;
    return (m_ones > RUN_LEN) ? RUN_LEN : m_ones;
  endfunction

  task automatic check(input string name, input logic ew, input int er, input int ed);
    n_vec++;
    if (w !== ew || run_cnt !== 3'(er) || det_cnt !== DET_W'(ed)) begin
      n_bad++;
      $display("FAIL %s @%0t: got w=%0b run_cnt=%0d det_cnt=%0d, expected w=%0b run_cnt=%0d det_cnt=%0d",
               name, $time, w, run_cnt, det_cnt, ew, er, ed);
    end
  endtask

  task automatic drive(input logic vj, ven, vmode, vclr, vrst);
    j = vj; en = ven; mode = vmode; clr = vclr; rst = vrst;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic vj, ven, vmode, vclr, vrst, vw, input int vrun, vdet);
    vec_t v;
    v.j = vj; v.en = ven; v.mode = vmode; v.clr = vclr; v.rst = vrst;
    v.w = vw; v.run = 3'(vrun); v.det = 2'(vdet);
    tbl.push_back(v);
  endtask

  task automatic add_ones(input int n, input logic vmode, input int det);
    for (int k = 1; k <= n; k++)
      add(1, 0, vmode, 0, 0, 0, (k > RUN_LEN) ? RUN_LEN : k, det);
  endtask

  initial begin
    j = 0; en = 0; mode = 0; clr = 0; rst = 1;

    // Exact match, acknowledge.
    add(0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add_ones(5, 0, 0);
    add(0, 0, 0, 0, 0, 1, 5, 1);
    add(1, 1, 0, 0, 0, 0, 0, 1);
    // Too long in exact mode, then at-least mode.
    add(0, 0, 0, 0, 0, 0, 0, 1);
    add_ones(5, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1);
    add_ones(6, 1, 1);
    add(0, 0, 1, 0, 0, 1, 5, 2);
    add(0, 1, 0, 0, 0, 0, 0, 2);
    // Short run re-arm.
    add(0, 0, 0, 0, 0, 0, 0, 2);
    add_ones(4, 0, 2);
    add(0, 0, 0, 0, 0, 0, 0, 2);
    add_ones(5, 0, 2);
    add(0, 0, 0, 0, 0, 1, 5, 3);
    add(0, 1, 0, 0, 0, 0, 0, 3);
    // No leading zero after reset.
    add(0, 0, 0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 5; k++) add(1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add_ones(5, 0, 0);
    add(0, 0, 0, 0, 0, 1, 5, 1);
    // Long hold with j toggling, then clr coincident with a HOLD entry.
    for (int k = 0; k < 10; k++) add(logic'(k % 2), 0, 0, 0, 0, 1, 5, 1);
    add(0, 1, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1);
    add_ones(5, 0, 1);
    add(0, 0, 0, 1, 0, 1, 5, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0);
    // Mode drops to exact while the run is past RUN_LEN.
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add_ones(7, 1, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1, 0);
    // Reset mid-run and in HOLD; a following 1 proves the state is IDLE.
    add(1, 0, 0, 0, 0, 0, 2, 0);
    add(1, 0, 0, 0, 0, 0, 3, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add_ones(5, 0, 0);
    add(0, 0, 0, 0, 0, 1, 5, 1);
    add(1, 1, 0, 1, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].j, tbl[i].en, tbl[i].mode, tbl[i].clr, tbl[i].rst);
      check($sformatf("table[%0d]", i), tbl[i].w, int'(tbl[i].run), int'(tbl[i].det));
    end

    // Counter saturation over five detections.
    drive(0, 0, 0, 0, 1);
    check("sat_reset", 0, 0, 0);
    for (int d = 1; d <= 5; d++) begin
      drive(0, 0, 0, 0, 0);
      for (int k = 0; k < RUN_LEN; k++) drive(1, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0);
      check($sformatf("sat_det%0d", d), 1, RUN_LEN, (d > DET_MAX) ? DET_MAX : d);
      drive(0, 1, 0, 0, 0);
      check($sformatf("sat_ack%0d", d), 0, 0, (d > DET_MAX) ? DET_MAX : d);
    end

    // Random stimulus against the reference model.
    drive(0, 0, 0, 0, 1);
    model_step(0, 0, 0, 0, 1);
    check("rand_reset", 0, 0, 0);
    begin
      logic rj, ren, rclr, rrst;
      logic rmode;
      rmode = 1'b0;
      for (int c = 0; c < 3000; c++) begin
        rj    = ($urandom_range(0, 99) < 72);
        ren   = ($urandom_range(0, 99) < 25);
        rclr  = ($urandom_range(0, 99) < 3);
        rrst  = ($urandom_range(0, 199) < 1);
        if ($urandom_range(0, 99) < 6) rmode = ~rmode;
        drive(rj, ren, rmode, rclr, rrst);
        model_step(rj, ren, rmode, rclr, rrst);
        check($sformatf("rand[%0d]", c), m_hold, model_run(), m_det);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/run_detector.md
# run_detector

Parametrised successor to the team's fixed "0, five 1s, 0" pattern detector. It samples a serial bit stream `j` and raises `w` after a zero-bracketed run of exactly (or at least) `RUN_LEN` ones. It holds `w` until the consumer acknowledges with `en`, and keeps a saturating count of detections. It sits between a serial line sampler and a control FSM that polls `w`.

## Interface
- `RUN_LEN`, default 5: number of ones in the target run; legal range ≥ 1.
- `DET_W`, default 8: width of the detection counter; legal range ≥ 1.
- `CW`: localparam, `$clog2(RUN_LEN+1)`; width of the run counter.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous active-high reset; highest priority.
- `j`  in  1  serial data bit, sampled every rising edge.
- `en`  in  1  acknowledge; only meaningful in HOLD.
- `mode`  in  1  0 = exact run length, 1 = at-least run length; sampled every cycle.
- `clr`  in  1  synchronous clear of `det_cnt`.
- `w`  out  1  detection flag; 1 iff state is HOLD; reset 0.
- `run_cnt`  out  CW  ones counted in the current run; reset 0.
- `det_cnt`  out  DET_W  number of entries into HOLD, saturating at all-ones; reset 0.

## Operation
- Moore FSM with four states: IDLE (waiting for a leading 0), ZERO (leading 0 seen), ONES (counting ones), HOLD (detected). Reset state is IDLE.
- IDLE: `j`=0 → ZERO; `j`=1 → IDLE.
- ZERO: `run_cnt`=0. `j`=0 → ZERO; `j`=1 → ONES with `run_cnt`=1.
- ONES, `j`=1, `run_cnt` < `RUN_LEN`: increment `run_cnt`, stay in ONES.
- ONES, `j`=1, `run_cnt` == `RUN_LEN`:
  - `mode`=0: go to IDLE, clear `run_cnt`. The run is too long; a fresh leading 0 is required.
  - `mode`=1: stay in ONES; `run_cnt` saturates at `RUN_LEN`.
- ONES, `j`=0:
  - `run_cnt` == `RUN_LEN`: go to HOLD and increment `det_cnt` (unless saturated).
  - Otherwise: go to ZERO and clear `run_cnt`. The terminating 0 doubles as the next leading 0.
- HOLD: `j` is ignored. `en`=1 → IDLE; `en`=0 → HOLD. `run_cnt` keeps `RUN_LEN` while in HOLD and clears on exit.
- Special case `RUN_LEN`=1: the first 1 makes `run_cnt`==`RUN_LEN` immediately; all rules above still apply.
- `det_cnt` priority, highest first: `rst`, then `clr`, then increment. If `clr` and a HOLD entry happen in the same cycle, the result is 0.
- Illegal state encodings → IDLE on the next edge.

## Timing
- `w` asserts on the edge that samples the terminating 0, i.e. one cycle after that 0 is presented. No combinational path from any input to `w`.
- `det_cnt` updates on the same edge that `w` rises.
- `en` high on edge k while in HOLD → `w` is 0 after edge k. Minimum HOLD duration is one cycle.
- After leaving HOLD, a new detection needs at least `RUN_LEN`+2 further samples (leading 0, the run, terminating 0).
- `rst` on any edge, including mid-run or in HOLD: next state IDLE; `w`, `run_cnt` and `det_cnt` all become 0. `en`, `clr` and `j` are ignored on that edge.
- `mode` changing mid-run takes effect on the next edge that evaluates the `run_cnt` == `RUN_LEN` condition.

## Structure
- Shared package `run_det_pkg` contains:
  - the state enum `run_det_state_t` (IDLE=0, ZERO=1, ONES=2, HOLD=3, 2-bit encoding);
  - the mode constants `MODE_EXACT`=0 and `MODE_ATLEAST`=1.
- One natural sub-module, `sat_counter`: a parametrised-width saturating up-counter with synchronous clear and increment enable. It is instantiated for `det_cnt`. `run_cnt` may reuse it, or be inline logic.

## Test plan
- Exact match: `RUN_LEN`=5, `mode`=0, `j` = 0,1,1,1,1,1,0 → `w`=1 after the 7th edge; `det_cnt`=1. Then `en`=1 for one cycle → `w`=0 on the next edge.
- Too long: `mode`=0, `j` = 0, six 1s, 0 → `w` stays 0. Repeat with `mode`=1 → `w`=1 after the terminating 0, with `run_cnt` held at 5.
- Short run re-arm: `j` = 0,1,1,1,1,0,1,1,1,1,1,0 → no detection at the first 0 after four 1s; `w`=1 after the final 0.
- No leading zero: from reset, `j` = 1,1,1,1,1,0 → `w`=0. Continuing with 1,1,1,1,1,0 → `w`=1, because the earlier 0 served as the leading 0.
- Hold and saturation: `DET_W`=2; hold `en`=0 for 10 cycles in HOLD while toggling `j` → `w` stays 1. Run 5 detections → `det_cnt`=3. Assert `clr` together with a HOLD entry → `det_cnt`=0.
- Reset mid-operation: assert `rst` with `run_cnt`=3, then again while in HOLD → all outputs 0 on the next edge; state IDLE.
